// File: rtl/intrpt_arbiter_pkg.sv
// Shared definitions for the slot interrupt arbiter: SPI command codes,
// slot index width and the status word layout.
package intrpt_arbiter_pkg;

    // Command codes decoded from the SPI command bus. Chosen in a block that is
    // not used by the existing command set.
    localparam logic [15:0] C_ACK_IRQ         = 16'h00A1;
    localparam logic [15:0] C_WRITE_IRQ_MASK  = 16'h00A2;
    localparam logic [15:0] C_READ_IRQ_STATUS = 16'h00A3;

    // Slot indices are always carried on 4 bits (up to 16 slots).
    localparam int SLOT_W = 4;

    // Status word returned to the MCU:
    // [3:0] cur_slot, [4] irq, [5] timeout sticky, [7:6] zero,
    // [23:8] pending, [39:24] mask.
    function automatic logic [39:0] pack_status(
        input logic [SLOT_W-1:0] cur_slot,
        input logic              irq,
        input logic              sticky,
        input logic [15:0]       pend16,
        input logic [15:0]       mask16
    );
        return {mask16, pend16, 2'b00, sticky, irq, cur_slot};
    endfunction

endpackage

// File: rtl/intrpt_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first eligible slot found
// when searching upward from rr_ptr+1, wrapping modulo NUM_SLOTS.
module intrpt_arbiter_rr_pick
    import intrpt_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic [NUM_SLOTS-1:0] eligible,
    input  logic [SLOT_W-1:0]    rr_ptr,
    output logic [SLOT_W-1:0]    grant,
    output logic                 grant_valid
);

    // Pick the eligible slot with the smallest forward distance from rr_ptr+1
    always_comb begin
        int dist_v;
        int best_v;
        grant       = 4'd0;
        grant_valid = 1'b0;
        best_v      = NUM_SLOTS;
        dist_v      = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            // rr_ptr is always < NUM_SLOTS, so this never goes negative
            dist_v = (i + NUM_SLOTS - 1 - int'(rr_ptr)) % NUM_SLOTS;
            if (eligible[i] && (dist_v < best_v)) begin
                best_v      = dist_v;
                grant       = 4'(i);
                grant_valid = 1'b1;
            end else begin
                best_v      = best_v;
            end
        end
    end

endmodule

// File: rtl/intrpt_arbiter.sv
// Slot interrupt arbiter: latches rising edges of the slot interrupt lines,
// grants one pending slot at a time round-robin on irq_out, and runs the
// MCU acknowledge handshake (with mask, minimum gap and ack timeout) over SPI.
module intrpt_arbiter
    import intrpt_arbiter_pkg::*;
#(
    parameter int DEV_ID         = 0,
    parameter int NUM_SLOTS      = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [15:0]          spi_cmd_r,
    input  logic [7:0]           spi_addr_r,
    input  logic [39:0]          spi_data_r,
    input  logic                 spi_data_valid_r,
    input  logic [15:0]          spi_cmd,
    input  logic [7:0]           spi_addr,
    output logic [39:0]          spi_data_out_r,
    input  logic [NUM_SLOTS-1:0] slot_intrpt,
    output logic                 irq_out
);

    generate
        if ((NUM_SLOTS < 2) || (NUM_SLOTS > 16)) begin : g_bad_num_slots
            $error("intrpt_arbiter: NUM_SLOTS must be within 2..16");
        end
        if ((GAP_CYCLES < 1) || (GAP_CYCLES > 65536)) begin : g_bad_gap
            $error("intrpt_arbiter: GAP_CYCLES must be within 1..65536");
        end
        if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65536)) begin : g_bad_timeout
            $error("intrpt_arbiter: TIMEOUT_CYCLES must be within 1..65536");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ASSERT = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    state_e                state_r;
    state_e                state_nxt_s;

    logic [NUM_SLOTS-1:0]  slot_sync_r;
    logic [NUM_SLOTS-1:0]  slot_dly_r;
    logic [NUM_SLOTS-1:0]  rise_s;
    logic [NUM_SLOTS-1:0]  pending_r;
    logic [NUM_SLOTS-1:0]  mask_r;
    logic [NUM_SLOTS-1:0]  eligible_s;
    logic [NUM_SLOTS-1:0]  clr_vec_s;
    logic [SLOT_W-1:0]     rr_ptr_r;
    logic [SLOT_W-1:0]     cur_slot_r;
    logic [SLOT_W-1:0]     grant_s;
    logic                  grant_vld_s;
    logic [15:0]           cnt_r;
    logic                  irq_out_r;
    logic                  irq_nxt_s;
    logic                  sticky_r;
    logic                  timeout_s;
    logic                  clr_cur_s;
    logic                  load_sel_s;
    logic                  cmd_hit_s;
    logic                  ack_s;
    logic                  mask_wr_s;
    logic                  rd_hit_s;
    logic [15:0]           pend16_s;
    logic [15:0]           mask16_s;
    logic [39:0]           stat_data_r;
    logic                  stat_oe_r;
    logic                  unused_data_s;

    // Only part of the payload is meaningful for these commands
    assign unused_data_s = ^spi_data_r;

    assign rise_s     = slot_sync_r & ~slot_dly_r;
    assign eligible_s = pending_r & mask_r;

    // SPI decode: write-side commands qualified by the valid strobe, the
    // status read decoded from the SDO-phase command/address
    assign cmd_hit_s = spi_data_valid_r && (spi_addr_r == 8'(DEV_ID));
    assign ack_s     = cmd_hit_s && (spi_cmd_r == C_ACK_IRQ) &&
                       (spi_data_r[3:0] == cur_slot_r) && (state_r == ST_ASSERT);
    assign mask_wr_s = cmd_hit_s && (spi_cmd_r == C_WRITE_IRQ_MASK);
    assign rd_hit_s  = (spi_cmd == C_READ_IRQ_STATUS) && (spi_addr == 8'(DEV_ID));

    intrpt_arbiter_rr_pick #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_rr_pick (
        .eligible    (eligible_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_valid (grant_vld_s)
    );

    // Input register plus delay stage used for rising-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_sync_r <= {NUM_SLOTS{1'b0}};
            slot_dly_r  <= {NUM_SLOTS{1'b0}};
        end else begin
            slot_sync_r <= slot_intrpt;
            slot_dly_r  <= slot_sync_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        irq_nxt_s   = 1'b0;
        timeout_s   = 1'b0;
        clr_cur_s   = 1'b0;
        load_sel_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // A mask write may have removed every candidate meanwhile
                if (grant_vld_s) begin
                    load_sel_s  = 1'b1;
                    irq_nxt_s   = 1'b1;
                    state_nxt_s = ST_ASSERT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // Ack wins over a timeout landing on the same cycle
                if (ack_s) begin
                    clr_cur_s   = 1'b1;
                    state_nxt_s = ST_GAP;
                end else if (cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_GAP;
                end else begin
                    irq_nxt_s   = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r == 16'(GAP_CYCLES - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Cycle counter shared by ASSERT (timeout) and GAP; restarts on every state change
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= 16'd0;
        end else if (state_nxt_s != state_r) begin
            cnt_r <= 16'd0;
        end else if ((state_r == ST_ASSERT) || (state_r == ST_GAP)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= 16'd0;
        end
    end

    // Registered interrupt line to the MCU
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_out_r <= 1'b0;
        end else begin
            irq_out_r <= irq_nxt_s;
        end
    end

    assign irq_out = irq_out_r;

    // One-hot clear of the slot being acknowledged
    always_comb begin
        clr_vec_s = {NUM_SLOTS{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (clr_cur_s && (cur_slot_r == 4'(i))) begin
                clr_vec_s[i] = 1'b1;
            end else begin
                clr_vec_s[i] = 1'b0;
            end
        end
    end

    // Pending events: a new rising edge beats a simultaneous ack clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_r <= {NUM_SLOTS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_vec_s) | rise_s;
        end
    end

    // Interrupt mask, all slots enabled out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_r <= {NUM_SLOTS{1'b1}};
        end else if (mask_wr_s) begin
            mask_r <= spi_data_r[NUM_SLOTS-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Granted slot and round-robin pointer, updated in SELECT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_r   <= 4'(NUM_SLOTS - 1);
            cur_slot_r <= 4'd0;
        end else if (load_sel_s) begin
            rr_ptr_r   <= grant_s;
            cur_slot_r <= grant_s;
        end else begin
            rr_ptr_r   <= rr_ptr_r;
            cur_slot_r <= cur_slot_r;
        end
    end

    // Timeout sticky flag: set by a timeout, cleared by a status read, set wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sticky_r <= 1'b0;
        end else if (timeout_s) begin
            sticky_r <= 1'b1;
        end else if (rd_hit_s) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    // Zero-extend slot vectors to the fixed 16-bit status fields
    always_comb begin
        pend16_s = 16'd0;
        mask16_s = 16'd0;
        pend16_s[NUM_SLOTS-1:0] = pending_r;
        mask16_s[NUM_SLOTS-1:0] = mask_r;
    end

    // Status read data, captured one cycle after the read is decoded
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_oe_r   <= 1'b0;
            stat_data_r <= 40'd0;
        end else if (rd_hit_s) begin
            stat_oe_r   <= 1'b1;
            stat_data_r <= pack_status(cur_slot_r, irq_out_r, sticky_r, pend16_s, mask16_s);
        end else begin
            stat_oe_r   <= 1'b0;
            stat_data_r <= stat_data_r;
        end
    end

    // The SDO bus is shared, so release it whenever this block is not addressed
    assign spi_data_out_r = stat_oe_r ? stat_data_r : {40{1'bz}};

endmodule
